// File: rtl/xy_router_vc.sv
// xy_router_vc: five-port mesh router node (PE, W, E, S, N) with per-input FIFOs,
// X-then-Y routing on the head flit, per-output round-robin arbitration and
// registered valid/ready outputs. Optional even/odd virtual-channel gating keyed to
// a free-running polarity bit.
module xy_router_vc #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 4,
    parameter int DEST_LSB   = 32,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0,
    parameter int VC_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    input  logic [4:0]              in_si,
    input  logic [5*DATA_WIDTH-1:0] in_di,
    output logic [4:0]              in_ri,
    output logic [4:0]              out_so,
    input  logic [4:0]              out_ro,
    output logic [5*DATA_WIDTH-1:0] out_do
);

    localparam int NP = 5;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] P_PE = 3'd0;
    localparam logic [2:0] P_W  = 3'd1;
    localparam logic [2:0] P_E  = 3'd2;
    localparam logic [2:0] P_S  = 3'd3;
    localparam logic [2:0] P_N  = 3'd4;

    localparam logic [COORD_W-1:0] CUR_X_C = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CUR_Y_C = COORD_W'(CUR_Y);

    logic [DATA_WIDTH-1:0] fifo_mem [NP][FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr   [NP];
    logic [AW-1:0]         wr_ptr   [NP];
    logic [CW-1:0]         count    [NP];
    logic [DATA_WIDTH-1:0] head     [NP];
    logic [2:0]            route    [NP];
    logic [2:0]            grant_idx[NP];
    logic [2:0]            arb_ptr  [NP];
    logic [NP-1:0]         push;
    logic [NP-1:0]         pop;
    logic [NP-1:0]         eligible;
    logic [NP-1:0]         load_ok;
    logic [NP-1:0]         grant_valid;

    // X first, then Y; a route back out of the arrival port is delivered locally instead.
    function automatic logic [2:0] xy_route(input logic [DATA_WIDTH-1:0] flit,
                                            input logic [2:0]            arrival);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [2:0]         r;
        dx = flit[DEST_LSB +: COORD_W];
        dy = flit[DEST_LSB + COORD_W +: COORD_W];
        if (dx > CUR_X_C)      r = P_E;
        else if (dx < CUR_X_C) r = P_W;
        else if (dy > CUR_Y_C) r = P_N;
        else if (dy < CUR_Y_C) r = P_S;
        else                   r = P_PE;
        if (r == arrival) r = P_PE;
        return r;
    endfunction

    // Round-robin candidate: base + k, wrapping 4 -> 0.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NP) s = s - NP;
        return 3'(s);
    endfunction

    // FIFO status, head-of-line route and eligibility, output slot availability
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_ri[p]    = (count[p] != DEPTH_C);
            push[p]     = in_si[p] && (count[p] != DEPTH_C);
            head[p]     = fifo_mem[p][rd_ptr[p]];
            route[p]    = xy_route(head[p], 3'(p));
            eligible[p] = (count[p] != '0) &&
                          ((VC_MODE == 0) || (head[p][DATA_WIDTH-1] == polarity));
            load_ok[p]  = !out_so[p] || out_ro[p];
        end
    end

    // Per-output round-robin search starting at the output's pointer
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            grant_valid[o] = 1'b0;
            grant_idx[o]   = 3'd0;
            for (int k = 0; k < NP; k++) begin
                if (load_ok[o] && !grant_valid[o] &&
                    eligible[rr_index(arb_ptr[o], k)] &&
                    (route[rr_index(arb_ptr[o], k)] == 3'(o))) begin
                    grant_valid[o] = 1'b1;
                    grant_idx[o]   = rr_index(arb_ptr[o], k);
                end
            end
        end
    end

    // Each input routes to exactly one output, so at most one grant pops a given FIFO
    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
        end
    end

    // Input FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) begin
                    fifo_mem[p][wr_ptr[p]] <= in_di[p*DATA_WIDTH +: DATA_WIDTH];
                    wr_ptr[p]              <= wr_ptr[p] + AW'(1);
                end
                if (pop[p]) rd_ptr[p] <= rd_ptr[p] + AW'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + CW'(1);
                    2'b01:   count[p] <= count[p] - CW'(1);
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // Output registers and arbiter pointers; a stalled slot holds its flit
    always_ff @(posedge clk) begin
        if (reset) begin
            out_so <= '0;
            out_do <= '0;
            for (int o = 0; o < NP; o++) arb_ptr[o] <= 3'd0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (grant_valid[o]) begin
                    out_do[o*DATA_WIDTH +: DATA_WIDTH] <= head[grant_idx[o]];
                    out_so[o]  <= 1'b1;
                    arb_ptr[o] <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
                end else if (out_ro[o]) begin
                    out_so[o] <= 1'b0;
                end
            end
        end
    end

    // Even/odd cycle marker for virtual-channel gating
    always_ff @(posedge clk) begin
        if (reset) polarity <= 1'b0;
        else       polarity <= ~polarity;
    end

endmodule
